// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and the memory (slave).
// A request is held with a stable address until the memory raises ready.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, output addr, input rdata, input ready);
    modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, drives a
// variable-latency instruction memory, and honours stall and branch/jump redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               if_id_valid,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic [31:0]        pc_out
);

    // FETCH: request outstanding at pc.
    // HOLD: one fetched word parked while decode stalls.
    // DRAIN: waiting out a wrong-path request before jumping to pend_pc.
    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] hold_buf;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4  = pc + 32'd4;
    assign imem.req  = !reset && (state != HOLD);
    assign imem.addr = pc;
    assign pc_out    = pc;

    // NOTE: all state updates use <= so every branch below sees the pre-edge values of pc, state and IF/ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pend_pc     <= RESET_PC;
            hold_buf    <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'h0000_0000;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.ready) begin
                        if (redirect) begin
                            pc          <= target;
                            if_id_valid <= 1'b0;
                            if_id_instr <= NOP_INSTR;
                        end else if (!stall) begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem.rdata;
                            if_id_pc4   <= pc_plus4;
                            pc          <= pc_plus4;
                        end else begin
                            hold_buf <= imem.rdata;
                            state    <= HOLD;
                        end
                    end else begin
                        // The request cannot be withdrawn, so a redirect must wait it out at the old address.
                        if (redirect) begin
                            pend_pc     <= target;
                            if_id_valid <= 1'b0;
                            if_id_instr <= NOP_INSTR;
                            state       <= DRAIN;
                        end else if (!stall) begin
                            if_id_valid <= 1'b0;
                            if_id_instr <= NOP_INSTR;
                        end
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc          <= target;
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        state       <= FETCH;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= hold_buf;
                        if_id_pc4   <= pc_plus4;
                        pc          <= pc_plus4;
                        state       <= FETCH;
                    end
                end

                DRAIN: begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                    if (redirect) begin
                        pend_pc <= target;
                    end
                    if (imem.ready) begin
                        pc    <= redirect ? target : pend_pc;
                        state <= FETCH;
                    end
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors with hand-computed
// IF/ID and PC values, followed by a wait-state stream checked for skips/duplicates.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [31:0] pc_out;
    logic        ready;

    int checks = 0;
    int errors = 0;

    fetch_stage_if imem ();

    // Memory responder: word at address a reads as a ^ KEY; garbage when not ready.
    assign imem.ready = ready;
    assign imem.rdata = ready ? (imem.addr ^ KEY) : 32'hDEAD_BEEF;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .pc_out      (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [31:0] e_pc;
        logic        e_req;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    task automatic add(input logic rst, input logic rdy, input logic stl, input logic rdr,
                       input logic [31:0] rpc, input logic e_valid, input logic [31:0] e_instr,
                       input logic [31:0] e_pc4, input logic [31:0] e_pc, input logic e_req);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_pc = e_pc; v.e_req = e_req;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_addr;
        int          got;
        int          want;

        //   rst rdy stl rdr rpc           valid instr          pc4            pc             req
        // Reset, then zero-wait streaming
        add(1, 1, 0, 0, 32'h0,         0, 32'h0,          32'h0,         32'h0,         0); // 0
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0000,  32'h4,         32'h4,         1); // 1
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0004,  32'h8,         32'h8,         1); // 2
        // Stall three cycles with ready=1 at pc=8 -> HOLD, request dropped, IF/ID frozen
        add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5_0004,  32'h8,         32'h8,         0); // 3
        add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5_0004,  32'h8,         32'h8,         0); // 4
        add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5_0004,  32'h8,         32'h8,         0); // 5
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0008,  32'hC,         32'hC,         1); // 6
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_000C,  32'h10,        32'h10,        1); // 7
        // Redirect to 0x40 with ready=1
        add(0, 1, 0, 1, 32'h40,        0, 32'h0,          32'h10,        32'h40,        1); // 8
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0040,  32'h44,        32'h44,        1); // 9
        // Move to 0x10, then redirect to 0x80 while the request waits
        add(0, 1, 0, 1, 32'h10,        0, 32'h0,          32'h44,        32'h10,        1); // 10
        add(0, 0, 0, 1, 32'h80,        0, 32'h0,          32'h44,        32'h10,        1); // 11
        add(0, 0, 0, 0, 32'h0,         0, 32'h0,          32'h44,        32'h10,        1); // 12
        add(0, 0, 1, 0, 32'h0,         0, 32'h0,          32'h44,        32'h10,        1); // 13
        add(0, 1, 0, 0, 32'h0,         0, 32'h0,          32'h44,        32'h80,        1); // 14
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0080,  32'h84,        32'h84,        1); // 15
        // DRAIN with a second redirect landing on the ready cycle (low bits forced to 00)
        add(0, 0, 0, 1, 32'h100,       0, 32'h0,          32'h84,        32'h84,        1); // 16
        add(0, 1, 0, 1, 32'h203,       0, 32'h0,          32'h84,        32'h200,       1); // 17
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0200,  32'h204,       32'h204,       1); // 18
        // Bubble on a wait state, then a stalled wait state holds IF/ID
        add(0, 0, 0, 0, 32'h0,         0, 32'h0,          32'h204,       32'h204,       1); // 19
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0204,  32'h208,       32'h208,       1); // 20
        add(0, 0, 1, 0, 32'h0,         1, 32'hA5A5_0204,  32'h208,       32'h208,       1); // 21
        // Redirect and stall together: flush wins
        add(0, 1, 1, 1, 32'h300,       0, 32'h0,          32'h208,       32'h300,       1); // 22
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0300,  32'h304,       32'h304,       1); // 23
        // Redirect out of HOLD discards the buffered word
        add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5_0300,  32'h304,       32'h304,       0); // 24
        add(0, 0, 1, 1, 32'h500,       0, 32'h0,          32'h304,       32'h500,       1); // 25
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0500,  32'h504,       32'h504,       1); // 26
        // Reset in HOLD, then redirect to the top of memory and wrap pc+4
        add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5_0500,  32'h504,       32'h504,       0); // 27
        add(1, 1, 1, 0, 32'h0,         0, 32'h0,          32'h0,         32'h0,         0); // 28
        add(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0,         32'hFFFF_FFFC, 1); // 29
        add(0, 1, 0, 0, 32'h0,         1, 32'h5A5A_FFFC,  32'h0,         32'h0,         1); // 30
        // Reset in DRAIN forgets the pending target
        add(0, 0, 0, 1, 32'h60,        0, 32'h0,          32'h0,         32'h0,         1); // 31
        add(1, 0, 0, 0, 32'h0,         0, 32'h0,          32'h0,         32'h0,         0); // 32
        add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5_0000,  32'h4,         32'h4,         1); // 33

        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            ready       = vecs[i].rdy;
            stall       = vecs[i].stl;
            redirect    = vecs[i].rdr;
            redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d instr", i), if_id_instr, vecs[i].e_instr);
            check($sformatf("v%0d pc4", i), if_id_pc4, vecs[i].e_pc4);
            check($sformatf("v%0d pc", i), pc_out, vecs[i].e_pc);
            check($sformatf("v%0d req", i), {31'b0, imem.req}, {31'b0, vecs[i].e_req});
            check($sformatf("v%0d addr", i), imem.addr, vecs[i].e_pc);
            @(negedge clk);
        end

        // Random wait states, no stall: every ready edge must deliver the next sequential word exactly once.
        reset    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        exp_addr = 32'h4;
        got      = 0;
        want     = 0;
        for (int c = 0; c < 40; c++) begin
            ready = 1'($urandom_range(0, 1));
            if (ready) want++;
            @(posedge clk);
            #1;
            check($sformatf("stream%0d valid", c), {31'b0, if_id_valid}, {31'b0, ready});
            if (if_id_valid) begin
                got++;
                check($sformatf("stream%0d instr", c), if_id_instr, exp_addr ^ KEY);
                check($sformatf("stream%0d pc4", c), if_id_pc4, exp_addr + 32'd4);
                exp_addr = exp_addr + 32'd4;
            end
            @(negedge clk);
        end
        check("stream count", got, want);
        check("stream pc", pc_out, exp_addr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
